// File: rtl/dat_phy.sv
// Single-line SD DAT PHY: serialises a TX FIFO block onto DAT or deserialises DAT into the RX FIFO.
// Optional CRC16-CCITT on the data bits when DAT_PHY_CRC16_EN is defined.
//
// state    | meaning
// IDLE     | accepting strobe_in, line released
// LOAD     | pop first TX word, wait one cycle, capture it
// WR_START | drive start bit (0)
// WR_DATA  | shift block out MSB first, prefetch next word
// WR_CRC   | shift 16 CRC bits out (CRC build only)
// WR_END   | drive end bit (1)
// RD_WAIT  | wait for start bit, bounded by TIMEOUT
// RD_DATA  | shift block in, push each completed word
// RD_CRC   | receive and compare 16 CRC bits (CRC build only)
// RD_END   | check end bit
// DONE     | hold complete until ack_in
module dat_phy #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  strobe_in,
  input  logic                  write_read,
  input  logic                  ack_in,
  output logic                  serial_ready,
  output logic                  complete,
  output logic                  ack_out,
  output logic                  data_error,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_full,
  output logic                  dat_out,
  output logic                  dat_oe,
  input  logic                  dat_in
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int WW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_PEN   = BW'(DATA_WIDTH - 2);
  localparam logic [WW-1:0] WORD_LAST = WW'(BLOCK_WORDS - 1);
  localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, WR_START, WR_DATA, WR_CRC, WR_END,
    RD_WAIT, RD_DATA, RD_CRC, RD_END, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]           word_cnt_q, word_cnt_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [DATA_WIDTH-1:0]   sh_q, sh_d;
  logic                    under_q, under_d;
  logic                    err_q, err_d;
  logic                    ack_q, ack_d;
  logic                    wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

`ifdef DAT_PHY_CRC16_EN
  logic [15:0] crc_q, crc_d;
  logic [3:0]  crc_cnt_q, crc_cnt_d;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    tmr_d        = tmr_q;
    sh_d         = sh_q;
    under_d      = under_q;
    err_d        = err_q;
    ack_d        = 1'b0;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
`ifdef DAT_PHY_CRC16_EN
    crc_d        = crc_q;
    crc_cnt_d    = crc_cnt_q;
`endif
    serial_ready = 1'b0;
    complete     = 1'b0;
    fifo_rd_en   = 1'b0;
    dat_oe       = 1'b0;
    dat_out      = 1'b1;

    case (state_q)
      IDLE: begin
        serial_ready = 1'b1;
        if (strobe_in) begin
          err_d      = 1'b0;
          under_d    = 1'b0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          tmr_d      = TMR_LOAD;
`ifdef DAT_PHY_CRC16_EN
          crc_d      = '0;
          crc_cnt_d  = '0;
`endif
          state_d    = write_read ? LOAD : RD_WAIT;
        end
      end
      LOAD: begin
        dat_oe = 1'b1;
        // bit_cnt doubles as the pop/wait phase flag here
        if (bit_cnt_q == '0) begin
          if (fifo_empty) begin
            under_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            fifo_rd_en = 1'b1;
          end
          bit_cnt_d = BW'(1);
        end else begin
          sh_d      = under_q ? '0 : fifo_rd_data;
          under_d   = 1'b0;
          bit_cnt_d = '0;
          state_d   = WR_START;
        end
      end
      WR_START: begin
        dat_oe  = 1'b1;
        dat_out = 1'b0;
        state_d = WR_DATA;
      end
      WR_DATA: begin
        dat_oe  = 1'b1;
        dat_out = sh_q[DATA_WIDTH-1];
`ifdef DAT_PHY_CRC16_EN
        crc_d   = crc_step(crc_q, sh_q[DATA_WIDTH-1]);
`endif
        if (bit_cnt_q == BIT_PEN && word_cnt_q != WORD_LAST) begin
          if (fifo_empty) begin
            under_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            fifo_rd_en = 1'b1;
          end
        end
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          sh_d      = under_q ? '0 : fifo_rd_data;
          under_d   = 1'b0;
          if (word_cnt_q == WORD_LAST) begin
            word_cnt_d = '0;
`ifdef DAT_PHY_CRC16_EN
            state_d    = WR_CRC;
`else
            state_d    = WR_END;
`endif
          end else begin
            word_cnt_d = word_cnt_q + WW'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          sh_d      = {sh_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
`ifdef DAT_PHY_CRC16_EN
      WR_CRC: begin
        dat_oe    = 1'b1;
        dat_out   = crc_q[15];
        crc_d     = {crc_q[14:0], 1'b0};
        crc_cnt_d = crc_cnt_q + 4'd1;
        if (crc_cnt_q == 4'd15) state_d = WR_END;
      end
`endif
      WR_END: begin
        dat_oe  = 1'b1;
        state_d = DONE;
      end
      RD_WAIT: begin
        if (!dat_in) begin
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = RD_DATA;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      RD_DATA: begin
        sh_d = {sh_q[DATA_WIDTH-2:0], dat_in};
`ifdef DAT_PHY_CRC16_EN
        crc_d = crc_step(crc_q, dat_in);
`endif
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (fifo_full) begin
            err_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = {sh_q[DATA_WIDTH-2:0], dat_in};
          end
          if (word_cnt_q == WORD_LAST) begin
            word_cnt_d = '0;
`ifdef DAT_PHY_CRC16_EN
            state_d    = RD_CRC;
`else
            state_d    = RD_END;
`endif
          end else begin
            word_cnt_d = word_cnt_q + WW'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
`ifdef DAT_PHY_CRC16_EN
      RD_CRC: begin
        if (dat_in != crc_q[15]) err_d = 1'b1;
        crc_d     = {crc_q[14:0], 1'b0};
        crc_cnt_d = crc_cnt_q + 4'd1;
        if (crc_cnt_q == 4'd15) state_d = RD_END;
      end
`endif
      RD_END: begin
        if (!dat_in) err_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        complete = 1'b1;
        if (ack_in) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      tmr_q      <= '0;
      sh_q       <= '0;
      under_q    <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
`ifdef DAT_PHY_CRC16_EN
      crc_q      <= '0;
      crc_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      tmr_q      <= tmr_d;
      sh_q       <= sh_d;
      under_q    <= under_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
`ifdef DAT_PHY_CRC16_EN
      crc_q      <= crc_d;
      crc_cnt_q  <= crc_cnt_d;
`endif
    end
  end

  assign ack_out      = ack_q;
  assign data_error   = err_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;

endmodule

// File: tb/tb_dat_phy.sv
// Self-checking bench for dat_phy: vector table, hand-written corner sequences and randomized blocks
// checked against a block-level model of the DAT line format.
module tb_dat_phy;

`ifdef DAT_PHY_CRC16_EN
  localparam int CRC_BITS = 16;
`else
  localparam int CRC_BITS = 0;
`endif

  logic       clock = 1'b0;
  logic       reset, strobe_in, write_read, ack_in;
  logic       serial_ready, complete, ack_out, data_error;
  logic       fifo_rd_en, fifo_empty, fifo_wr_en, fifo_full;
  logic [7:0] fifo_rd_data = 8'h00;
  logic [7:0] fifo_wr_data;
  logic       dat_out, dat_oe, dat_in;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] tx_mem [0:1023];
  logic [7:0] rx_mem [0:1023];
  int tx_wr = 0;
  int tx_rd = 0;
  int rx_n = 0;
  int rd_pulses = 0;

  dat_phy #(.DATA_WIDTH(8), .BLOCK_WORDS(4), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .strobe_in(strobe_in), .write_read(write_read),
    .ack_in(ack_in), .serial_ready(serial_ready), .complete(complete), .ack_out(ack_out),
    .data_error(data_error), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .dat_out(dat_out), .dat_oe(dat_oe), .dat_in(dat_in)
  );

  always #5 clock = ~clock;

  assign fifo_empty = (tx_rd >= tx_wr);

  // TX FIFO: pop on rd_en, data valid the cycle after
  always @(posedge clock) begin
    if (fifo_rd_en) begin
      rd_pulses <= rd_pulses + 1;
      if (tx_rd < tx_wr) begin
        fifo_rd_data <= tx_mem[tx_rd];
        tx_rd <= tx_rd + 1;
      end
    end
  end

  always @(posedge clock) begin
    if (fifo_wr_en) begin
      rx_mem[rx_n] <= fifo_wr_data;
      rx_n <= rx_n + 1;
    end
  end

  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic b);
    crc_next = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_ack();
    tick();
    tick();
    chk("complete_held", complete, 1);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("ack_pulse", ack_out, 1);
    chk("complete_clr", complete, 0);
    chk("ready_back", serial_ready, 1);
    tick();
    chk("ack_one_cycle", ack_out, 0);
  endtask

  task automatic do_write(input logic [31:0] data, input int avail, input logic exp_err);
    logic        exp_bits[$];
    logic [15:0] c;
    logic [7:0]  w;
    int          rd0;
    tx_wr = tx_rd;
    for (int k = 0; k < avail; k++) begin
      tx_mem[tx_wr] = data[31-8*k -: 8];
      tx_wr++;
    end
    c = 16'h0000;
    exp_bits.push_back(1'b0);
    for (int k = 0; k < 4; k++) begin
      w = (k < avail) ? data[31-8*k -: 8] : 8'h00;
      for (int b = 7; b >= 0; b--) begin
        exp_bits.push_back(w[b]);
        c = crc_next(c, w[b]);
      end
    end
    for (int b = CRC_BITS - 1; b >= 0; b--) exp_bits.push_back(c[b]);
    exp_bits.push_back(1'b1);

    rd0 = rd_pulses;
    chk("wr_idle_ready", serial_ready, 1);
    strobe_in = 1'b1;
    write_read = 1'b1;
    tick();
    strobe_in = 1'b0;
    chk("wr_ready_drop", serial_ready, 0);
    chk("load0_line", {dat_oe, dat_out}, 2'b11);
    tick();
    chk("load1_line", {dat_oe, dat_out}, 2'b11);
    for (int i = 0; i < exp_bits.size(); i++) begin
      tick();
      chk($sformatf("wr_bit%0d", i), {dat_oe, dat_out}, {1'b1, exp_bits[i]});
    end
    tick();
    chk("wr_done_oe", dat_oe, 0);
    chk("wr_complete", complete, 1);
    chk("wr_error", data_error, exp_err);
    chk("wr_pops", rd_pulses - rd0, (avail < 4) ? avail : 4);
    do_ack();
  endtask

  task automatic do_read(input logic [31:0] data, input int idle, input logic end_bit,
                         input logic [3:0] full_mask, input logic flip, input logic exp_err);
    logic [7:0]  exp_words[$];
    logic [15:0] c;
    int          rx0;
    rx0 = rx_n;
    for (int k = 0; k < 4; k++)
      if (!full_mask[k]) exp_words.push_back(data[31-8*k -: 8]);
    dat_in = 1'b1;
    strobe_in = 1'b1;
    write_read = 1'b0;
    tick();
    strobe_in = 1'b0;
    chk("rd_wait_oe", dat_oe, 0);
    repeat (idle) tick();
    dat_in = 1'b0;
    tick();
    c = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      fifo_full = full_mask[i/8];
      dat_in = data[31-i];
      c = crc_next(c, data[31-i]);
      tick();
    end
    fifo_full = 1'b0;
    for (int b = CRC_BITS - 1; b >= 0; b--) begin
      dat_in = c[b] ^ (flip && b == 0);
      tick();
    end
    dat_in = end_bit;
    tick();
    dat_in = 1'b1;
    chk("rd_complete", complete, 1);
    chk("rd_error", data_error, exp_err);
    chk("rd_push_count", rx_n - rx0, exp_words.size());
    for (int j = 0; j < exp_words.size(); j++)
      chk($sformatf("rd_word%0d", j), rx_mem[rx0+j], exp_words[j]);
    do_ack();
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] data;
    int          avail;
    int          idle;
    logic        end_bit;
    logic [3:0]  full;
    logic        flip;
    logic        exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] d;
    int          av, idl;
    logic        eb, fl;
    logic [3:0]  fm;
    int          rx0;

    tbl[0] = '{1'b1, 32'hA53CFF00, 4, 0, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'h11223344, 2, 0, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 32'h12345678, 0, 10, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'h12345678, 0, 3, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 32'hCAFEBABE, 0, 0, 1'b1, 4'b0100, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 32'h0F0F0F0F, 0, 5, 1'b1, 4'b0000, 1'b1, (CRC_BITS != 0)};

    reset = 1'b1; strobe_in = 1'b0; write_read = 1'b0; ack_in = 1'b0;
    fifo_full = 1'b0; dat_in = 1'b1;
    tick();
    tick();
    chk("rst_ready", serial_ready, 1);
    chk("rst_complete", complete, 0);
    chk("rst_ack", ack_out, 0);
    chk("rst_error", data_error, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_line", {dat_oe, dat_out}, 2'b01);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      if (tbl[v].wr) do_write(tbl[v].data, tbl[v].avail, tbl[v].exp_err);
      else do_read(tbl[v].data, tbl[v].idle, tbl[v].end_bit, tbl[v].full, tbl[v].flip, tbl[v].exp_err);
    end

    // read timeout: no start bit within 64 cycles of RD_WAIT entry
    rx0 = rx_n;
    dat_in = 1'b1;
    strobe_in = 1'b1;
    write_read = 1'b0;
    tick();
    strobe_in = 1'b0;
    repeat (63) tick();
    chk("tmo_not_yet", complete, 0);
    tick();
    chk("tmo_complete", complete, 1);
    chk("tmo_error", data_error, 1);
    chk("tmo_no_push", rx_n - rx0, 0);
    do_ack();

    // reset mid-write, with a stray strobe first that must be ignored
    tx_wr = tx_rd;
    for (int k = 0; k < 4; k++) begin
      tx_mem[tx_wr] = 8'h5A;
      tx_wr++;
    end
    strobe_in = 1'b1;
    write_read = 1'b1;
    tick();
    strobe_in = 1'b0;
    repeat (12) tick();
    strobe_in = 1'b1;
    write_read = 1'b0;
    tick();
    strobe_in = 1'b0;
    chk("stray_strobe_oe", dat_oe, 1);
    chk("stray_strobe_ready", serial_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_line", {dat_oe, dat_out}, 2'b01);
    chk("abort_ready", serial_ready, 1);
    do_write(32'hDEADBEEF, 4, 1'b0);

    for (int r = 0; r < 8; r++) begin
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        av = $urandom_range(1, 4);
        do_write(d, av, av < 4);
      end else begin
        idl = $urandom_range(0, 40);
        eb = ($urandom_range(0, 3) != 0);
        fm = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        fl = (CRC_BITS != 0) && ($urandom_range(0, 3) == 0);
        do_read(d, idl, eb, fm, fl, !eb || (fm != 4'b0000) || fl);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
